// File: rtl/acia_tx_fifo.sv
// acia_tx_fifo: 6551-style UART transmitter with write FIFO, 5-8 bit words, parity and 1/2 stop bits.
// Optional break output is enabled by defining ACIA_TX_BREAK_EN (adds input TXBRK).
module acia_tx_fifo #(
  parameter int FIFO_DEPTH = 4,
  parameter int OVERSAMPLE = 16,
  parameter int LVL_W      = 5
) (
  input  logic             PHI2,
  input  logic             RESET,
  input  logic             BAUD_TICK,
  input  logic             CTSB,
  input  logic [7:0]       TXDATA,
  input  logic             TXLATCH,
  input  logic [1:0]       R_WL,
  input  logic             R_PME,
  input  logic [1:0]       R_PMC,
  input  logic             R_SBN,
`ifdef ACIA_TX_BREAK_EN
  input  logic             TXBRK,
`endif
  output logic             TX,
  output logic             TXFULL,
  output logic             TXEMPTY,
  output logic [LVL_W-1:0] TXLEVEL,
  output logic             TXOVR
);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int TW = $clog2(OVERSAMPLE);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, STOP2} state_t;
  logic [7:0]       r_mem [FIFO_DEPTH];
  logic [PW-1:0]    r_wp, r_rp;
  logic [LVL_W-1:0] r_level;
  logic             r_full, r_empty, r_ovr, r_tx, r_par, r_pme, r_sbn;
  logic [1:0]       r_wl, r_pmc;
  logic [7:0]       r_sh;
  logic [2:0]       r_bit;
  logic [TW-1:0]    r_tick;
  state_t           r_state;
  logic             w_brk, w_pop, w_push, w_tend, w_last, w_stop2, w_p, w_pbit;
  logic [2:0]       w_last_bit;
  logic [LVL_W-1:0] w_lvl_nxt;
`ifdef ACIA_TX_BREAK_EN
  assign w_brk = TXBRK;
`else
  assign w_brk = 1'b0;
`endif
  assign w_pop      = BAUD_TICK && r_state == IDLE && r_level != '0 && !CTSB && !w_brk;
  assign w_push     = TXLATCH && (!r_full || w_pop);
  assign w_lvl_nxt  = r_level + LVL_W'(w_push) - LVL_W'(w_pop);
  assign w_tend     = r_tick == TW'(OVERSAMPLE - 1);
  assign w_stop2    = r_sbn && !r_pme;
  assign w_last     = BAUD_TICK && w_tend && (r_state == STOP2 || (r_state == STOP && !w_stop2));
  assign w_last_bit = 3'd7 - {1'b0, r_wl};
  // parity including the data bit currently on the line
  assign w_p        = r_par ^ r_sh[0];
  assign w_pbit     = r_pmc[1] ? ~r_pmc[0] : (r_pmc[0] ? w_p : ~w_p);
  assign TX      = r_tx;
  assign TXFULL  = r_full;
  assign TXEMPTY = r_empty;
  assign TXLEVEL = r_level;
  assign TXOVR   = r_ovr;
  always_ff @(posedge PHI2)
    if (w_push) r_mem[r_wp] <= TXDATA;
  always_ff @(posedge PHI2 or negedge RESET) begin
    if (!RESET) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_level <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
      r_ovr   <= 1'b0;
      r_tx    <= 1'b1;
      r_par   <= 1'b0;
      r_pme   <= 1'b0;
      r_sbn   <= 1'b0;
      r_wl    <= '0;
      r_pmc   <= '0;
      r_sh    <= '0;
      r_bit   <= '0;
      r_tick  <= '0;
      r_state <= IDLE;
    end else begin
      if (w_push) r_wp <= r_wp + PW'(1);
      if (w_pop) r_rp <= r_rp + PW'(1);
      if (TXLATCH && !w_push) r_ovr <= 1'b1;
      r_level <= w_lvl_nxt;
      r_full  <= w_lvl_nxt == LVL_W'(FIFO_DEPTH);
      r_empty <= w_lvl_nxt == '0 && ((r_state == IDLE && !w_pop) || w_last);
      r_tick  <= (BAUD_TICK && r_state != IDLE) ? (w_tend ? '0 : r_tick + TW'(1)) : r_tick;
      case (r_state)
        IDLE:
          if (w_pop) begin
            r_sh    <= r_mem[r_rp];
            r_wl    <= R_WL;
            r_pme   <= R_PME;
            r_pmc   <= R_PMC;
            r_sbn   <= R_SBN;
            r_par   <= 1'b0;
            r_tx    <= 1'b0;
            r_state <= START;
          end else r_tx <= !w_brk;
        START:
          if (BAUD_TICK && w_tend) begin
            r_bit   <= '0;
            r_tx    <= r_sh[0];
            r_state <= DATA;
          end
        DATA:
          if (BAUD_TICK && w_tend) begin
            r_par <= w_p;
            r_sh  <= r_sh >> 1;
            r_bit <= r_bit + 3'd1;
            if (r_bit == w_last_bit) begin
              r_state <= r_pme ? PARITY : STOP;
              r_tx    <= r_pme ? w_pbit : 1'b1;
            end else r_tx <= r_sh[1];
          end
        PARITY:
          if (BAUD_TICK && w_tend) begin
            r_tx    <= 1'b1;
            r_state <= STOP;
          end
        STOP:
          if (BAUD_TICK && w_tend) r_state <= w_stop2 ? STOP2 : IDLE;
        STOP2:
          if (BAUD_TICK && w_tend) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_acia_tx_fifo.sv
// tb_acia_tx_fifo: scoreboard bench for acia_tx_fifo; frames are predicted at push time and checked bit-by-bit on TX.
module tb_acia_tx_fifo;
  logic       PHI2 = 0, RESET = 0, BAUD_TICK = 0, CTSB = 1, TXLATCH = 0, R_PME = 0, R_SBN = 0, TXBRK = 0;
  logic [7:0] TXDATA = 0;
  logic [1:0] R_WL = 0, R_PMC = 0;
  logic       TX, TXFULL, TXEMPTY, TXOVR;
  logic [4:0] TXLEVEL;
  int         n_chk = 0, n_err = 0, b_cnt = 0;
  logic       q_exp[$];
  int         q_len[$];

  acia_tx_fifo dut (
    .PHI2(PHI2), .RESET(RESET), .BAUD_TICK(BAUD_TICK), .CTSB(CTSB), .TXDATA(TXDATA),
    .TXLATCH(TXLATCH), .R_WL(R_WL), .R_PME(R_PME), .R_PMC(R_PMC), .R_SBN(R_SBN),
`ifdef ACIA_TX_BREAK_EN
    .TXBRK(TXBRK),
`endif
    .TX(TX), .TXFULL(TXFULL), .TXEMPTY(TXEMPTY), .TXLEVEL(TXLEVEL), .TXOVR(TXOVR)
  );

  always #5 PHI2 = ~PHI2;

  initial forever begin
    @(negedge PHI2);
    BAUD_TICK = b_cnt == 3;
    b_cnt = (b_cnt + 1) % 4;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cfg(input logic [1:0] wl, input logic pme, input logic [1:0] pmc, input logic sbn);
    R_WL = wl; R_PME = pme; R_PMC = pmc; R_SBN = sbn;
  endtask

  task automatic expect_frame(input logic [7:0] d);
    int n, len;
    logic p;
    n = 8 - int'(R_WL);
    p = 1'b0;
    q_exp.push_back(1'b0);
    len = 1;
    for (int i = 0; i < n; i++) begin
      q_exp.push_back(d[i]);
      p ^= d[i];
      len++;
    end
    if (R_PME) begin
      q_exp.push_back(R_PMC == 2'd0 ? ~p : R_PMC == 2'd1 ? p : R_PMC == 2'd2);
      len++;
    end
    q_exp.push_back(1'b1);
    len++;
    if (R_SBN && !R_PME) begin
      q_exp.push_back(1'b1);
      len++;
    end
    q_len.push_back(len);
  endtask

  task automatic push(input logic [7:0] d, input bit sb);
    if (sb) expect_frame(d);
    TXDATA = d;
    TXLATCH = 1;
    @(negedge PHI2);
    TXLATCH = 0;
  endtask

  task automatic rx_frame(input string tag, output int gap);
    int len;
    logic b;
    len = q_len.pop_front();
    gap = 0;
    do begin
      @(negedge PHI2);
      gap++;
    end while (TX !== 1'b0 && gap < 4000);
    if (TX !== 1'b0) begin
      check({tag, "_nostart"}, TX, 0);
      repeat (len) void'(q_exp.pop_front());
      return;
    end
    repeat (31) @(negedge PHI2);
    for (int i = 0; i < len; i++) begin
      if (i != 0) repeat (64) @(negedge PHI2);
      b = q_exp.pop_front();
      check(tag, TX, b);
    end
    check({tag, "_busy"}, TXEMPTY, 0);
  endtask

  initial begin
    int g, to;
    repeat (3) @(negedge PHI2);
    check("rst_tx", TX, 1);
    check("rst_full", TXFULL, 0);
    check("rst_empty", TXEMPTY, 1);
    check("rst_lvl", TXLEVEL, 0);
    check("rst_ovr", TXOVR, 0);
    RESET = 1;
    repeat (2) @(negedge PHI2);

    cfg(2'd0, 0, 2'd0, 0);
    CTSB = 0;
    push(8'hA5, 1);
    rx_frame("f8n1", g);
    repeat (40) @(negedge PHI2);
    check("empty_8n1", TXEMPTY, 1);
    check("idle_8n1", TX, 1);

    cfg(2'd1, 1, 2'd1, 0);
    push(8'h83, 1);
    rx_frame("f7e1", g);

    cfg(2'd3, 0, 2'd0, 1);
    push(8'h1F, 1);
    rx_frame("f5n2", g);
    repeat (40) @(negedge PHI2);
    check("empty_5n2", TXEMPTY, 1);

    cfg(2'd3, 1, 2'd2, 1);
    push(8'h1F, 1);
    rx_frame("f5m1", g);
    repeat (40) @(negedge PHI2);
    check("one_stop", TXEMPTY, 1);

    cfg(2'd0, 0, 2'd0, 0);
    CTSB = 1;
    for (int i = 0; i < 5; i++) push(8'h30 + 8'(i * 7), i < 4);
    check("fifo_lvl", TXLEVEL, 4);
    check("fifo_full", TXFULL, 1);
    check("fifo_ovr", TXOVR, 1);
    check("fifo_nempty", TXEMPTY, 0);
    repeat (20) @(negedge PHI2);
    check("cts_hold", TX, 1);
    CTSB = 0;
    for (int i = 0; i < 4; i++) begin
      rx_frame("burst", g);
      if (i > 0) check("b2b_gap", g, 37);
      check("lvl_dec", TXLEVEL, 3 - i);
    end
    check("full_clr", TXFULL, 0);

    push(8'h5A, 1);
    push(8'hC3, 1);
    fork
      rx_frame("cts1", g);
      begin
        repeat (150) @(negedge PHI2);
        CTSB = 1;
      end
    join
    repeat (200) @(negedge PHI2);
    check("cts_tx", TX, 1);
    check("cts_lvl", TXLEVEL, 1);
    check("cts_nempty", TXEMPTY, 0);
    CTSB = 0;
    rx_frame("cts2", g);

    cfg(2'd0, 1, 2'd1, 0);
    repeat (60) @(negedge PHI2);
    push(8'h00, 0);
    to = 0;
    while (TX !== 1'b0 && to < 2000) begin
      @(negedge PHI2);
      to++;
    end
    check("rst_fall", TX, 0);
    for (int i = 0; i < 5; i++) push(8'h11 * 8'(i + 1), 0);
    check("pre_lvl", TXLEVEL, 4);
    check("pre_full", TXFULL, 1);
    repeat (595) @(negedge PHI2);
    check("par_bit", TX, 0);
    #2 RESET = 0;
    #1;
    check("arst_tx", TX, 1);
    check("arst_lvl", TXLEVEL, 0);
    check("arst_full", TXFULL, 0);
    check("arst_ovr", TXOVR, 0);
    check("arst_empty", TXEMPTY, 1);
    @(negedge PHI2);
    RESET = 1;
    cfg(2'd0, 0, 2'd0, 0);
    @(negedge PHI2);
    push(8'h00, 1);
    rx_frame("post_rst", g);
    check("sb_drain", q_exp.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/acia_tx_fifo.md
Name: acia_tx_fifo

Overview:
- Parametrised successor to the ACIA transmitter: 6551-style UART TX with a write FIFO, programmable word length (5-8 bits), parity and stop-bit control.
- Runs entirely in the PHI2 domain. The bit rate comes from a single-cycle BAUD_TICK enable (16x oversample) produced by the baud generator, so no second clock domain or CDC handshake is needed.
- Sits between the ACIA register file (TXDATA write, control/command bits) and the TX pin.

Parameters:
- FIFO_DEPTH, 4, TX FIFO entries; power of two, range 2..16
- OVERSAMPLE, 16, BAUD_TICK pulses per bit period; range 4..16
- LVL_W, 5, width of TXLEVEL; must satisfy 2^LVL_W > FIFO_DEPTH

Ports:
- PHI2  in  1  system clock; all logic on rising edge
- RESET  in  1  asynchronous active-low reset
- BAUD_TICK  in  1  one-PHI2-cycle enable at 16x baud (OVERSAMPLE x baud)
- CTSB  in  1  clear-to-send, active low
- TXDATA  in  8  byte to transmit; LSB first
- TXLATCH  in  1  push TXDATA into FIFO (one-cycle strobe)
- R_WL  in  2  word length: 00=8, 01=7, 10=6, 11=5 bits
- R_PME  in  1  parity enable
- R_PMC  in  2  parity mode: 00 odd, 01 even, 10 mark, 11 space
- R_SBN  in  1  stop bits: 0=1, 1=2 (2 only when R_PME=0)
- TX  out  1  serial output, idle high
- TXFULL  out  1  FIFO full
- TXEMPTY  out  1  FIFO empty and FSM in IDLE (line quiet)
- TXLEVEL  out  LVL_W  current FIFO occupancy
- TXOVR  out  1  sticky: push attempted while full; cleared by reset only

Behaviour:
- Reset (async, RESET=0):
  - TX=1, TXFULL=0, TXEMPTY=1, TXLEVEL=0, TXOVR=0.
  - FIFO pointers cleared, FSM=IDLE, bit and tick counters 0.
  - Reset mid-character aborts immediately; TX returns high asynchronously.
- FIFO write:
  - TXLATCH=1 and not full: entry written, TXLEVEL increments next cycle.
  - TXLATCH=1 while full: data dropped, TXOVR set. Exception: a pop in the same cycle makes the push legal; it is accepted and TXLEVEL is unchanged.
  - Simultaneous push and pop when not full: TXLEVEL unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - TXFULL = (TXLEVEL==FIFO_DEPTH), registered with TXLEVEL.
- FSM states: IDLE, START, DATA, PARITY, STOP, STOP2. All state and counter advances are qualified by BAUD_TICK.
  - IDLE: TX=1. On BAUD_TICK with FIFO non-empty and CTSB=0:
    - pop the head entry into the shifter;
    - latch R_WL, R_PME, R_PMC, R_SBN for the whole character;
    - clear running parity; go to START.
    - TX falls on the PHI2 edge after that tick.
  - START: TX=0 for OVERSAMPLE ticks, then DATA.
  - DATA: TX=shifter[0]. After OVERSAMPLE ticks: XOR the bit into parity, shift right, increment bit count.
    - After N bits (N from latched R_WL): go to PARITY if latched PME=1, else STOP.
    - Only the N low bits of the entry are sent; upper bits are ignored.
  - PARITY: TX = ~par (odd), par (even), 1 (mark), 0 (space) for OVERSAMPLE ticks, then STOP.
  - STOP: TX=1 for OVERSAMPLE ticks. Then go to STOP2 if latched SBN=1 and PME=0, else IDLE.
  - STOP2: TX=1 for OVERSAMPLE ticks, then IDLE.
- Character length in ticks = OVERSAMPLE x (1 start + N data + P parity + S stop).
- Back-to-back characters: IDLE lasts exactly one BAUD_TICK between characters when data is pending.
- CTSB is sampled only in IDLE. Deasserting CTSB mid-character lets that character complete; the FSM then holds in IDLE.
- Register changes mid-character do not affect the character in flight.
- TXEMPTY = FIFO empty and FSM==IDLE, registered.

Optional Feature:
- Macro ACIA_TX_BREAK_EN.
- Defined: adds input TXBRK (1 bit). While TXBRK=1 and FSM is in IDLE, TX is driven 0 and no FIFO pop occurs. A character in flight completes before break begins. When TXBRK drops, TX returns to 1 and normal pops resume on the next BAUD_TICK.
- Undefined: port absent; IDLE drives TX=1 unconditionally.

Test Plan:
- 8N1 (R_WL=00, PME=0, SBN=0), BAUD_TICK every 4 PHI2, push 0xA5 -> TX = 0,1,0,1,0,0,1,0,1,1; each bit is 16 ticks = 64 PHI2; TXEMPTY=1 after stop bit.
- 7E1 (R_WL=01, PME=1, PMC=01), push 0x83 -> data bits 1,1,0,0,0,0,0 then parity 0 then stop 1; bit 7 not sent.
- 5N2 (R_WL=11, SBN=1), push 0x1F -> 5 ones, then 2 stop bits (32 ticks high); with PME=1 and PMC=10, exactly 1 stop bit follows a mark parity bit of 1.
- FIFO_DEPTH=4, CTSB=1, push 5 bytes -> TXLEVEL=4, TXFULL=1, TXOVR=1. Release CTSB -> 4 bytes sent back-to-back in order; TXLEVEL decrements at each START.
- Deassert CTSB during DATA of byte 1 with 2 bytes queued -> byte 1 completes, TX holds 1, TXLEVEL=1. Reassert CTSB -> byte 2 sent.
- Assert RESET during PARITY -> TX=1, TXLEVEL=0, TXFULL=0 immediately. After release, push 0x00 -> clean 8N1 frame.
